// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, state/owner encodings and output index map for the FFT frame scheduler
package fft_pkg;

   localparam int N_PTS  = 2048;
   localparam int BANK_W = 2;
   localparam int ADDR_W = 9;
   localparam int IDX_W  = BANK_W + ADDR_W;

   localparam logic [IDX_W-1:0] N_LAST = IDX_W'(N_PTS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_RUN    = 2'd2,
      ST_UNLOAD = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE     = 2'd0,
      OWN_LOADER   = 2'd1,
      OWN_CORE     = 2'd2,
      OWN_UNLOADER = 2'd3
   } owner_t;

   // Natural-order output k lives at the mixed-radix digit-reversed location (1 radix-2 + 5 radix-4 digits).
   function automatic logic [IDX_W-1:0] out_index(input logic [IDX_W-1:0] k);
      return {k[0], k[2:1], k[4:3], k[6:5], k[8:7], k[10:9]};
   endfunction

endpackage

// File: rtl/fft_skid_fifo.sv
// rtl/fft_skid_fifo.sv - small circular FIFO absorbing in-flight RAM reads under output backpressure
module fft_skid_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             clr,
   input  logic             s_tvalid,
   input  logic [WIDTH-1:0] s_tdata,
   output logic             m_tvalid,
   output logic [WIDTH-1:0] m_tdata,
   input  logic             m_tready,
   output logic [OCC_W-1:0] occupancy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [OCC_W-1:0] count;
   logic             push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Space is guaranteed by the caller's issue credit, so pushes are unconditional.
   assign push      = s_tvalid;
   assign pop       = m_tvalid && m_tready;
   assign m_tvalid  = (count != '0);
   assign m_tdata   = mem[rd_ptr];
   assign occupancy = count;

   always_ff @(posedge iCLK) begin
      if (push) mem[wr_ptr] <= s_tdata;
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fft_frame_sched.sv
// rtl/fft_frame_sched.sv - LOAD/RUN/UNLOAD frame scheduler owning the RAM A port mux of the 2048-pt FFT
module fft_frame_sched
   import fft_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int RD_LAT     = 2,
   parameter int SKID_DEPTH = 4
) (
   input  logic              iCLK,
   input  logic              iRESET,
   input  logic              iFLUSH,
   input  logic              iIN_VALID,
   input  logic [DATA_W-1:0] iIN_RE,
   input  logic [DATA_W-1:0] iIN_IM,
   output logic              oIN_READY,
   output logic              oCORE_START,
   input  logic              iCORE_RDY,
   output logic [1:0]        oMUX_OWNER,
   output logic              oRAM_WE,
   output logic [1:0]        oRAM_BANK,
   output logic [8:0]        oRAM_ADDR,
   output logic [DATA_W-1:0] oRAM_WRE,
   output logic [DATA_W-1:0] oRAM_WIM,
   input  logic [DATA_W-1:0] iRAM_RD_RE,
   input  logic [DATA_W-1:0] iRAM_RD_IM,
   output logic              oOUT_VALID,
   output logic [DATA_W-1:0] oOUT_RE,
   output logic [DATA_W-1:0] oOUT_IM,
   output logic              oOUT_LAST,
   input  logic              iOUT_READY,
   output logic              oBUSY,
   output logic              oFRAME_DONE
);

   localparam int OCC_W = $clog2(SKID_DEPTH + 1);
   localparam logic [OCC_W:0] CREDIT = (OCC_W + 1)'(SKID_DEPTH);

   state_t              state_q, state_d;
   owner_t              owner;
   logic [IDX_W-1:0]    load_n_q, rd_k_q, out_k_q, rd_j;
   logic                rd_done_q, owner_none_q, armed_q, frame_done_q;
   logic [1:0]          run_cnt_q;
   logic [RD_LAT-1:0]   rd_pipe_q;
   logic [OCC_W:0]      in_flight;
   logic [OCC_W-1:0]    fifo_occ;
   logic                fifo_valid;
   logic [2*DATA_W-1:0] fifo_dout;
   logic                accept, issue, pop, last_pop, core_go;

   // armed_q keeps oIN_READY low while reset is held so every output reads 0 in reset.
   assign oIN_READY   = armed_q && (state_q == ST_IDLE || state_q == ST_LOAD);
   assign accept      = oIN_READY && iIN_VALID;
   assign oCORE_START = (state_q == ST_RUN) && (run_cnt_q == 2'd0);
   assign core_go     = (state_q == ST_RUN) && (run_cnt_q == 2'd2) && iCORE_RDY;
   assign rd_j        = out_index(rd_k_q);
   assign pop         = fifo_valid && iOUT_READY;
   assign last_pop    = pop && (out_k_q == N_LAST);

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + {{OCC_W{1'b0}}, rd_pipe_q[i]};
   end

   // Reads already in the RAM pipeline count against FIFO space, so a stalled sink never overflows it.
   assign issue = (state_q == ST_UNLOAD) && !rd_done_q && (({1'b0, fifo_occ} + in_flight) < CREDIT);

   always_comb begin
      state_d = state_q;
      if (iFLUSH) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (accept) state_d = ST_LOAD;
            ST_LOAD:   if (accept && load_n_q == N_LAST) state_d = ST_RUN;
            ST_RUN:    if (core_go) state_d = ST_UNLOAD;
            ST_UNLOAD: if (last_pop) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      owner = OWN_NONE;
      case (state_q)
         ST_IDLE, ST_LOAD: owner = owner_none_q ? OWN_NONE : OWN_LOADER;
         ST_RUN:           owner = OWN_CORE;
         ST_UNLOAD:        owner = OWN_UNLOADER;
         default:          owner = OWN_NONE;
      endcase
   end

   always_comb begin
      oRAM_BANK = '0;
      oRAM_ADDR = '0;
      if (state_q == ST_IDLE || state_q == ST_LOAD) {oRAM_BANK, oRAM_ADDR} = load_n_q;
      else if (state_q == ST_UNLOAD)                {oRAM_BANK, oRAM_ADDR} = rd_j;
   end

   assign oMUX_OWNER  = owner;
   assign oRAM_WE     = accept;
   assign oRAM_WRE    = accept ? iIN_RE : '0;
   assign oRAM_WIM    = accept ? iIN_IM : '0;
   assign oOUT_VALID  = fifo_valid;
   assign oOUT_RE     = fifo_valid ? fifo_dout[2*DATA_W-1:DATA_W] : '0;
   assign oOUT_IM     = fifo_valid ? fifo_dout[DATA_W-1:0] : '0;
   assign oOUT_LAST   = fifo_valid && (out_k_q == N_LAST);
   assign oBUSY       = (state_q != ST_IDLE);
   assign oFRAME_DONE = frame_done_q;

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q      <= ST_IDLE;
         load_n_q     <= '0;
         rd_k_q       <= '0;
         out_k_q      <= '0;
         rd_done_q    <= 1'b0;
         owner_none_q <= 1'b1;
         armed_q      <= 1'b0;
         frame_done_q <= 1'b0;
         run_cnt_q    <= 2'd0;
         rd_pipe_q    <= '0;
      end else begin
         armed_q <= 1'b1;
         state_q <= state_d;
         if (iFLUSH) begin
            load_n_q     <= '0;
            rd_k_q       <= '0;
            out_k_q      <= '0;
            rd_done_q    <= 1'b0;
            owner_none_q <= 1'b1;
            frame_done_q <= 1'b0;
            run_cnt_q    <= 2'd0;
            rd_pipe_q    <= '0;
         end else begin
            frame_done_q <= last_pop;
            rd_pipe_q    <= (rd_pipe_q << 1) | RD_LAT'(issue);
            if (accept) begin
               owner_none_q <= 1'b0;
               load_n_q     <= (load_n_q == N_LAST) ? '0 : load_n_q + IDX_W'(1);
            end
            // run_cnt_q saturates at 2 so the sequencer's stale ready level is ignored for two cycles.
            if (state_q == ST_RUN) run_cnt_q <= (run_cnt_q == 2'd2) ? 2'd2 : run_cnt_q + 2'd1;
            else                   run_cnt_q <= 2'd0;
            if (issue) begin
               if (rd_k_q == N_LAST) rd_done_q <= 1'b1;
               else                  rd_k_q    <= rd_k_q + IDX_W'(1);
            end
            if (pop) out_k_q <= (out_k_q == N_LAST) ? '0 : out_k_q + IDX_W'(1);
            if (last_pop) begin
               rd_k_q    <= '0;
               rd_done_q <= 1'b0;
            end
         end
      end
   end

   fft_skid_fifo #(
      .DEPTH (SKID_DEPTH),
      .WIDTH (2 * DATA_W)
   ) u_skid (
      .iCLK      (iCLK),
      .iRESET    (iRESET),
      .clr       (iFLUSH),
      .s_tvalid  (rd_pipe_q[RD_LAT-1]),
      .s_tdata   ({iRAM_RD_RE, iRAM_RD_IM}),
      .m_tvalid  (fifo_valid),
      .m_tdata   (fifo_dout),
      .m_tready  (iOUT_READY),
      .occupancy (fifo_occ)
   );

endmodule

// File: tb/tb_fft_frame_sched.sv
// tb/tb_fft_frame_sched.sv - directed/randomized self-checking bench for fft_frame_sched with a RAM echo model
module tb_fft_frame_sched;

   localparam int N = 2048;

   logic        iCLK = 1'b0;
   logic        iRESET, iFLUSH, iIN_VALID, iCORE_RDY, iOUT_READY;
   logic [15:0] iIN_RE, iIN_IM, ram_rd_re, ram_rd_im;
   logic        oIN_READY, oCORE_START, oRAM_WE, oOUT_VALID, oOUT_LAST, oBUSY, oFRAME_DONE;
   logic [1:0]  oMUX_OWNER, oRAM_BANK;
   logic [8:0]  oRAM_ADDR;
   logic [15:0] oRAM_WRE, oRAM_WIM, oOUT_RE, oOUT_IM;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] mem [N];
   logic [10:0] a1, a2;
   logic [15:0] im_ref [N];
   logic [83:0] all_out;

   fft_frame_sched dut (
      .iCLK(iCLK), .iRESET(iRESET), .iFLUSH(iFLUSH),
      .iIN_VALID(iIN_VALID), .iIN_RE(iIN_RE), .iIN_IM(iIN_IM), .oIN_READY(oIN_READY),
      .oCORE_START(oCORE_START), .iCORE_RDY(iCORE_RDY), .oMUX_OWNER(oMUX_OWNER),
      .oRAM_WE(oRAM_WE), .oRAM_BANK(oRAM_BANK), .oRAM_ADDR(oRAM_ADDR),
      .oRAM_WRE(oRAM_WRE), .oRAM_WIM(oRAM_WIM),
      .iRAM_RD_RE(ram_rd_re), .iRAM_RD_IM(ram_rd_im),
      .oOUT_VALID(oOUT_VALID), .oOUT_RE(oOUT_RE), .oOUT_IM(oOUT_IM), .oOUT_LAST(oOUT_LAST),
      .iOUT_READY(iOUT_READY), .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE)
   );

   always #5 iCLK = ~iCLK;

   // RAM A with a two-cycle read latency.
   always @(posedge iCLK) begin
      a1 <= {oRAM_BANK, oRAM_ADDR};
      a2 <= a1;
      if (oRAM_WE) mem[{oRAM_BANK, oRAM_ADDR}] <= {oRAM_WRE, oRAM_WIM};
   end
   assign ram_rd_re = mem[a2][31:16];
   assign ram_rd_im = mem[a2][15:0];

   assign all_out = {oIN_READY, oCORE_START, oMUX_OWNER, oRAM_WE, oRAM_BANK, oRAM_ADDR, oRAM_WRE,
                     oRAM_WIM, oOUT_VALID, oOUT_RE, oOUT_IM, oOUT_LAST, oBUSY, oFRAME_DONE};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Location read for natural-order output k: low bit becomes the top radix-2 digit, then radix-4 digits reversed.
   function automatic int ref_index(input int k);
      int r, j;
      j = (k % 2) * 1024;
      r = k / 2;
      for (int d = 0; d < 5; d++) begin
         j += (r % 4) * (256 >> (2 * d));
         r /= 4;
      end
      return j;
   endfunction

   task automatic load_frame(input int valid_pct, input int flush_at);
      int n, cyc, we_cnt, bad;
      n = 0; cyc = 0; we_cnt = 0; bad = 0;
      while (n < N && cyc < 20000) begin
         @(negedge iCLK);
         if (n == flush_at) begin
            iIN_VALID = 1'b0;
            iFLUSH    = 1'b1;
            @(negedge iCLK);
            iFLUSH = 1'b0;
            #1;
            check("flush_load_busy", 32'(oBUSY), 32'd0);
            check("flush_load_owner", 32'(oMUX_OWNER), 32'd0);
            check("flush_load_ready", 32'(oIN_READY), 32'd1);
            check("flush_load_we_cnt", 32'(we_cnt), 32'(flush_at));
            return;
         end
         iIN_VALID = ($urandom_range(0, 99) < valid_pct);
         iIN_RE    = 16'(n);
         iIN_IM    = 16'($urandom);
         #1;
         if (oRAM_WE) we_cnt++;
         if (iIN_VALID && oIN_READY) begin
            if ({oRAM_BANK, oRAM_ADDR} !== 11'(n) || oRAM_WRE !== iIN_RE || oRAM_WIM !== iIN_IM) bad++;
            if (n > 0 && oMUX_OWNER !== 2'd1) bad++;
            im_ref[n] = iIN_IM;
            n++;
         end
         cyc++;
      end
      check("load_beats", 32'(n), 32'(N));
      check("load_we_cnt", 32'(we_cnt), 32'(N));
      check("load_write_bad", 32'(bad), 32'd0);
   endtask

   task automatic run_phase(input int low_cycles, input int reset_at);
      int len, starts;
      bit entered;
      len = 0; starts = 0; entered = 0;
      for (int i = 0; i < low_cycles + 50; i++) begin
         @(negedge iCLK);
         iIN_VALID = 1'b0;
         iCORE_RDY = (i < 2 || i >= 2 + low_cycles);
         if (i == reset_at) begin
            iRESET    = 1'b0;
            iIN_VALID = 1'b1;
            iIN_RE    = 16'hBEEF;
            #1;
            check("rst_mid_run_outs", 32'(|all_out), 32'd0);
            check("rst_mid_run_busy", 32'(oBUSY), 32'd0);
            @(negedge iCLK);
            iRESET    = 1'b1;
            iIN_VALID = 1'b0;
            iCORE_RDY = 1'b1;
            return;
         end
         #1;
         if (i == 0) check("run_in_ready", 32'(oIN_READY), 32'd0);
         if (oCORE_START) starts++;
         if (oMUX_OWNER == 2'd3) begin
            entered = 1'b1;
            break;
         end
         if (oMUX_OWNER == 2'd2 && oBUSY) len++;
      end
      check("run_len", 32'(len), 32'(3 + low_cycles));
      check("core_start_cnt", 32'(starts), 32'd1);
      check("unload_entered", 32'(entered), 32'd1);
      iCORE_RDY = 1'b1;
   endtask

   task automatic unload_frame(input int ready_pct, input int flush_at);
      int k, cyc, done_cnt, j;
      k = 0; cyc = 0; done_cnt = 0;
      while (k < N && cyc < 30000) begin
         @(negedge iCLK);
         iOUT_READY = ($urandom_range(0, 99) < ready_pct);
         if (k == flush_at) begin
            iFLUSH = 1'b1;
            @(negedge iCLK);
            iFLUSH     = 1'b0;
            iOUT_READY = 1'b1;
            #1;
            check("flush_unl_busy", 32'(oBUSY), 32'd0);
            check("flush_unl_owner", 32'(oMUX_OWNER), 32'd0);
            check("flush_unl_valid", 32'(oOUT_VALID), 32'd0);
            for (int c = 0; c < 8; c++) begin
               @(negedge iCLK);
               #1;
               if (oFRAME_DONE || oOUT_VALID || oBUSY) done_cnt++;
            end
            check("flush_unl_quiet", 32'(done_cnt), 32'd0);
            return;
         end
         #1;
         if (oFRAME_DONE) done_cnt++;
         if (oOUT_VALID && iOUT_READY) begin
            j = ref_index(k);
            check($sformatf("out_re[%0d]", k), 32'(oOUT_RE), 32'(j));
            check($sformatf("out_im[%0d]", k), 32'(oOUT_IM), 32'(im_ref[j]));
            check($sformatf("out_last[%0d]", k), 32'(oOUT_LAST), 32'(k == N - 1));
            k++;
         end
         cyc++;
      end
      check("unload_beats", 32'(k), 32'(N));
      check("done_early", 32'(done_cnt), 32'd0);
      @(negedge iCLK);
      iOUT_READY = 1'b0;
      #1;
      check("frame_done", 32'(oFRAME_DONE), 32'd1);
      check("done_busy", 32'(oBUSY), 32'd0);
      check("done_owner", 32'(oMUX_OWNER), 32'd1);
      check("done_in_ready", 32'(oIN_READY), 32'd1);
      @(negedge iCLK);
      #1;
      check("frame_done_pulse", 32'(oFRAME_DONE), 32'd0);
   endtask

   initial begin
      iRESET     = 1'b0;
      iFLUSH     = 1'b0;
      iIN_VALID  = 1'b1;
      iIN_RE     = 16'h1234;
      iIN_IM     = 16'h5678;
      iCORE_RDY  = 1'b1;
      iOUT_READY = 1'b1;
      repeat (2) @(negedge iCLK);
      #1;
      check("reset_outs", 32'(|all_out), 32'd0);
      check("reset_owner", 32'(oMUX_OWNER), 32'd0);
      @(negedge iCLK);
      iRESET    = 1'b1;
      iIN_VALID = 1'b0;

      // Gappy load, long core run, 30% sink duty.
      load_frame(70, -1);
      run_phase(600, -1);
      unload_frame(30, -1);

      // Abort mid-load, then abort mid-unload.
      load_frame(80, 1000);
      load_frame(100, -1);
      run_phase(50, -1);
      unload_frame(100, 500);

      // Clean frame after the aborts.
      load_frame(60, -1);
      run_phase(20, -1);
      unload_frame(60, -1);

      // Async reset in RUN, then a frame whose core ready is already high at START.
      load_frame(100, -1);
      run_phase(100, 10);
      load_frame(100, -1);
      run_phase(0, -1);
      unload_frame(100, -1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
